mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit for the MIPS core. Executes MULT, MULTU, DIV and DIVU over several cycles.
//  Holds the architectural HI/LO registers and serves MFHI/MFLO, MTHI/MTLO.
//  Sits beside the EX stage. The hazard unit stalls on busy when a later HI/LO access arrives.
// PARAMETERS
//  WIDTH     32  operand/HI/LO width in bits.
//  MUL_STEP  1   multiplier bits retired per cycle; must divide WIDTH (1,2,4,8).
// PORTS
//  clk      in   1      clock; all state updates on rising edge.
//  rst_n    in   1      asynchronous, active-low reset.
//  start    in   1      launch op with a/b; sampled only when idle.
//  op       in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, others reserved.
//  a        in   WIDTH  rs operand (multiplicand / dividend).
//  b        in   WIDTH  rt operand (multiplier / divisor).
//  cancel   in   1      pipeline flush; aborts an op in flight.
//  wr_hi    in   1      MTHI write strobe.
//  wr_lo    in   1      MTLO write strobe.
//  wdata    in   WIDTH  MTHI/MTLO data.
//  busy     out  1      op in flight; HI/LO not yet valid.
//  done     out  1      one-cycle pulse; new HI/LO is visible this cycle.
//  hi       out  WIDTH  HI register.
//  lo       out  WIDTH  LO register.
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, busy=0, done=0, hi=0, lo=0, counter and datapath cleared.
//  FSM states: IDLE, RUN, FIX.
//   IDLE->RUN on start with a valid op. The operand magnitudes and result signs are latched at that edge.
//   RUN iterates: multiply is shift-add of MUL_STEP bits/cycle over N=WIDTH/MUL_STEP cycles; divide is restoring, 1 bit/cycle, N=WIDTH cycles.
//   RUN->FIX after the last iteration. FIX applies sign correction (and accumulate for MADD) and writes HI/LO. FIX->IDLE always.
//  Latency:
//   busy=1 for N+1 cycles, starting the cycle after the start edge.
//   done=1 and new hi/lo are visible in the first cycle after busy falls.
//   Defaults: MULT gives done 34 cycles after start; DIV also 34.
//  Results:
//   MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned.
//   DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, which takes the sign of the dividend.
//   DIV of most-negative by -1: lo = 0x80000000, hi = 0. No trap.
//   Divide by zero, any signedness: lo = all-ones, hi = a. No trap. Still takes full latency.
//  Handshake:
//   start while busy is ignored.
//   Reserved op code (or MADD/MADDU with the feature off): start is ignored; busy stays 0 and done is never pulsed.
//  cancel:
//   While busy: the next edge returns the FSM to IDLE. hi/lo keep their pre-op values and done is not pulsed.
//   start and cancel in the same cycle: cancel wins; nothing is launched.
//   cancel while idle: no effect.
//  MTHI/MTLO:
//   When idle, wr_hi/wr_lo load wdata at the next edge; both may be written in the same cycle.
//   Ignored while busy; the pipeline stalls them.
//   start together with wr_* in the same idle cycle: start wins and the write is dropped.
//  Reset mid-operation: immediate abort to reset values, with no done pulse.
// CONFIGURATION
//  MDU_MADD_EN defined:
//   op 100 MADD gives {hi,lo} += signed product; op 101 MADDU gives {hi,lo} += unsigned product.
//   The sum wraps modulo 2^(2*WIDTH). Latency is the same as MULT.
//   The accumulator base is the {hi,lo} value captured at the start edge.
//  MDU_MADD_EN undefined: ops 100/101 are reserved, handled as above; the accumulate adder is not built.
// TESTING
//  1. Reset with rst_n=0 mid-DIV -> busy=0, done=0, hi=lo=0 immediately. No done pulse after release.
//  2. MULT a=0xFFFFFFFF(-1), b=0x00000002 -> 34 cycles later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//     MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
//  3. DIV a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//     DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
//     DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. MTHI 0x1234 first; then MULTU 5*6 with cancel asserted on busy cycle 10 -> busy drops next cycle.
//     No done pulse; hi=0x1234, lo=0. A start pulsed while busy was never accepted.
//  5. MUL_STEP=4 build: MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 9 cycles.
//     Result hi=0xFFFFFFFE, lo=0x00000001.
//  6. MDU_MADD_EN: preload hi=0, lo=0xFFFFFFFF; MADDU 1*1 -> hi=1, lo=0.
//     Same sequence without the macro -> start ignored, busy stays 0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the EX-stage pipeline (master) and the HI/LO multiply/divide unit (slave).
// Combinational bundle only; busy is the sole backpressure back to the pipeline.
// No storage here; the bundle adds no latency.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel, wr_hi, wr_lo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel, wr_hi, wr_lo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MADD/MADDU are built only with MDU_MADD_EN defined.
// Latency: busy for N+1 cycles (N = WIDTH/MUL_STEP for multiply, WIDTH for divide), done pulses the cycle after.
// Backpressure: start and MTHI/MTLO are dropped while busy; the hazard unit must stall on busy.
module mult_div_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);
    localparam int MUL_N = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   dvsr;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
`ifdef MDU_MADD_EN
    logic               is_madd;
    logic               op_madd;
`endif

    logic               op_ok;
    logic               op_signed;
    logic               op_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               launch;

    always_comb begin
        op_ok     = 1'b0;
        op_signed = 1'b0;
        op_div    = 1'b0;
`ifdef MDU_MADD_EN
        op_madd   = 1'b0;
`endif
        case (bus.op)
            3'b000: begin op_ok = 1'b1; op_signed = 1'b1; end
            3'b001: begin op_ok = 1'b1; end
            3'b010: begin op_ok = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
            3'b011: begin op_ok = 1'b1; op_div = 1'b1; end
`ifdef MDU_MADD_EN
            3'b100: begin op_ok = 1'b1; op_signed = 1'b1; op_madd = 1'b1; end
            3'b101: begin op_ok = 1'b1; op_madd = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign sign_a = op_signed & bus.a[WIDTH-1];
    assign sign_b = op_signed & bus.b[WIDTH-1];
    assign a_mag  = sign_a ? -bus.a : bus.a;
    assign b_mag  = sign_b ? -bus.b : bus.b;
    assign launch = bus.start & op_ok & ~bus.cancel;

    // One iteration step. acc holds {partial product, remaining multiplier}
    // for multiply and {partial remainder, dividend/quotient} for divide.
    logic [WIDTH+MUL_STEP-1:0] pp;
    logic [WIDTH+MUL_STEP-1:0] mul_sum;
    logic [WIDTH:0]            div_t;
    logic [WIDTH-1:0]          div_diff;
    logic                      div_ge;
    logic [2*WIDTH-1:0]        acc_nxt;

    always_comb begin
        pp       = {{MUL_STEP{1'b0}}, dvsr} * {{WIDTH{1'b0}}, acc[MUL_STEP-1:0]};
        mul_sum  = {{MUL_STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]} + pp;
        div_t    = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = div_t >= {1'b0, dvsr};
        div_diff = div_t[WIDTH-1:0] - dvsr;
        if (is_div)
            acc_nxt = {(div_ge ? div_diff : div_t[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        else
            acc_nxt = {mul_sum, acc[WIDTH-1:MUL_STEP]};
    end

    // Sign fix-up. A zero divisor leaves the dividend magnitude as remainder,
    // so re-applying the dividend sign gives hi = a without a special case.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] fix_val;

    always_comb begin
        prod    = neg_q ? -acc : acc;
        fix_val = prod;
`ifdef MDU_MADD_EN
        // hi/lo cannot change while busy, so they still hold the start-edge base.
        if (is_madd)
            fix_val = prod + {hi_q, lo_q};
`endif
        if (is_div) begin
            fix_val[WIDTH-1:0]       = div_zero ? {WIDTH{1'b1}}
                                     : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            fix_val[2*WIDTH-1:WIDTH] = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            dvsr     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_MADD_EN
            is_madd  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state    <= RUN;
                        busy_q   <= 1'b1;
                        is_div   <= op_div;
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= (bus.b == '0);
                        cnt      <= op_div ? CW'(WIDTH - 1) : CW'(MUL_N - 1);
                        acc      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        dvsr     <= op_div ? b_mag : a_mag;
`ifdef MDU_MADD_EN
                        is_madd  <= op_madd;
`endif
                    end else begin
                        if (bus.wr_hi)
                            hi_q <= bus.wdata;
                        if (bus.wr_lo)
                            lo_q <= bus.wdata;
                    end
                end
                RUN: begin
                    if (bus.cancel) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0)
                            state <= FIX;
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (!bus.cancel) begin
                        hi_q   <= fix_val[2*WIDTH-1:WIDTH];
                        lo_q   <= fix_val[WIDTH-1:0];
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised self-checking bench for mult_div_unit against an arithmetic reference model.
// A second instance built with MUL_STEP=4 covers the multi-bit multiply step.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();
    mult_div_unit_if #(.WIDTH(32)) bus4 ();

    mult_div_unit #(.WIDTH(32), .MUL_STEP(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mult_div_unit #(.WIDTH(32), .MUL_STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] base);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    if (op == 3'd2) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd4: p = base + (sa * sb);
            3'd5: p = base + ({32'd0, a} * {32'd0, b});
            default: p = base;
        endcase
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0;  bus.op = 0;  bus.a = 0;  bus.b = 0;
        bus.cancel = 0; bus.wr_hi = 0; bus.wr_lo = 0; bus.wdata = 0;
        bus4.start = 0; bus4.op = 0; bus4.a = 0; bus4.b = 0;
        bus4.cancel = 0; bus4.wr_hi = 0; bus4.wr_lo = 0; bus4.wdata = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        exp_hi = '0;
        exp_lo = '0;
    endtask

    // Launch one op on the main instance and follow it to done.
    // With gap=0 the caller issues the next start in the done cycle itself.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name, input bit gap);
        logic [63:0] r;
        int k, nb;
        r = ref_model(op, a, b, {exp_hi, exp_lo});
        bus.start = 1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        bus.start = 0; bus.wr_hi = 0; bus.wr_lo = 0;
        k = 1;
        nb = 0;
        while (!bus.done && k < 100) begin
            if (bus.busy) nb++;
            tick();
            k++;
        end
        checks++;
        if (k !== 34) begin
            errors++;
            $display("FAIL %s latency: got %0d want 34", name, k);
        end
        checks++;
        if (nb !== 33) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want 33", name, nb);
        end
        checks++;
        if ({bus.hi, bus.lo} !== r) begin
            errors++;
            $display("FAIL %s result op=%0d a=%h b=%h: got %h_%h want %h_%h",
                     name, op, a, b, bus.hi, bus.lo, r[63:32], r[31:0]);
        end
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        if (gap) begin
            tick();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse: done=%b busy=%b want 0 0", name, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0;
        idle_inputs();
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h want zeros", bus.busy, bus.done, bus.hi, bus.lo);
        end
        rst_n = 1'b1;
        tick();
        bus.wr_hi = 1; bus.wr_lo = 1; bus.wdata = 32'hA5A5_0001;
        tick();
        bus.wr_hi = 0; bus.wr_lo = 0;
        checks++;
        if (bus.hi !== 32'hA5A5_0001 || bus.lo !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h want a5a50001", bus.hi, bus.lo);
        end
        bus.start = 1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.start = 0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_mid_div: busy=%b done=%b hi=%h lo=%h want zeros", bus.busy, bus.done, bus.hi, bus.lo);
        end
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles want 0", seen);
        end
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_mult();
        run_op(3'd0, 32'hFFFF_FFFF, 32'h2, "mult_neg1x2", 1);
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mult_const: hi=%h lo=%h want ffffffff fffffffe", bus.hi, bus.lo);
        end
        run_op(3'd1, 32'hFFFF_FFFF, 32'h2, "multu_ffx2", 1);
        checks++;
        if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu_const: hi=%h lo=%h want 00000001 fffffffe", bus.hi, bus.lo);
        end
        for (int i = 0; i < 6; i++)
            run_op(3'($urandom_range(0, 1)), $urandom, $urandom, "mult_rand", 1);
    endtask

    task automatic test_div();
        logic [31:0] b;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1);
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_const: hi=%h lo=%h want ffffffff fffffffd", bus.hi, bus.lo);
        end
        run_op(3'd3, 32'd7, 32'd0, "divu_by0", 1);
        checks++;
        if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd7) begin
            errors++;
            $display("FAIL divu_zero_const: hi=%h lo=%h want 00000007 ffffffff", bus.hi, bus.lo);
        end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg", 1);
        checks++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            errors++;
            $display("FAIL div_minneg_const: hi=%h lo=%h want 00000000 80000000", bus.hi, bus.lo);
        end
        run_op(3'd2, 32'hFFFF_FFF0, 32'd0, "div_neg_by0", 1);
        for (int i = 0; i < 6; i++) begin
            b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = -b;
            run_op(3'($urandom_range(2, 3)), $urandom, b, "div_rand", 1);
        end
    endtask

    task automatic test_cancel_mthi();
        int seen;
        do_reset();
        bus.wr_hi = 1; bus.wdata = 32'h1234;
        tick();
        bus.wr_hi = 0;
        exp_hi = 32'h1234;
        bus.start = 1; bus.op = 3'd1; bus.a = 32'd5; bus.b = 32'd6;
        tick();
        bus.start = 0;
        for (int k = 1; k < 10; k++) begin
            if (k == 5) begin
                bus.start = 1; bus.op = 3'd3; bus.a = 32'd9; bus.b = 32'd3;
                bus.wr_lo = 1; bus.wdata = 32'hDEAD;
            end else begin
                bus.start = 0; bus.wr_lo = 0;
            end
            tick();
        end
        bus.start = 0; bus.wr_lo = 0;
        bus.cancel = 1;
        tick();
        bus.cancel = 0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL cancel_busy_drop: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL cancel_no_done: got %0d active cycles want 0", seen);
        end
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL cancel_keeps_hilo: hi=%h lo=%h want 00001234 00000000", bus.hi, bus.lo);
        end
        // start wins over a same-cycle MTHI
        bus.wr_hi = 1; bus.wdata = 32'hBEEF;
        run_op(3'd1, 32'd3, 32'd4, "start_beats_mthi", 1);
        // reserved op is ignored, later MTLO under idle cancel still lands
        bus.start = 1; bus.op = 3'd7; bus.a = 32'd3; bus.b = 32'd3;
        tick();
        bus.start = 0;
        seen = 0;
        for (int i = 0; i < 36; i++) begin
            if (bus.busy || bus.done) seen++;
            tick();
        end
        checks++;
        if (seen !== 0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL reserved_op: active=%0d hi=%h lo=%h want 0 %h %h", seen, bus.hi, bus.lo, exp_hi, exp_lo);
        end
        bus.cancel = 1; bus.wr_lo = 1; bus.wdata = 32'h55;
        tick();
        bus.cancel = 0; bus.wr_lo = 0;
        exp_lo = 32'h55;
        checks++;
        if (bus.lo !== 32'h55 || bus.hi !== exp_hi) begin
            errors++;
            $display("FAIL idle_cancel_mtlo: hi=%h lo=%h want %h 00000055", bus.hi, bus.lo, exp_hi);
        end
    endtask

    task automatic test_step4();
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [63:0] r;
        int k, nb;
        for (int t = 0; t < 4; t++) begin
            if (t == 0) begin
                op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
            end else begin
                op = 3'($urandom_range(0, 1)); a = $urandom; b = $urandom;
            end
            r = ref_model(op, a, b, 64'd0);
            bus4.start = 1; bus4.op = op; bus4.a = a; bus4.b = b;
            tick();
            bus4.start = 0;
            k = 1;
            nb = 0;
            while (!bus4.done && k < 60) begin
                if (bus4.busy) nb++;
                tick();
                k++;
            end
            checks++;
            if (nb !== 9 || k !== 10) begin
                errors++;
                $display("FAIL step4_latency: busy=%0d done_at=%0d want 9 10", nb, k);
            end
            checks++;
            if ({bus4.hi, bus4.lo} !== r) begin
                errors++;
                $display("FAIL step4_result op=%0d a=%h b=%h: got %h_%h want %h_%h",
                         op, a, b, bus4.hi, bus4.lo, r[63:32], r[31:0]);
            end
            tick();
        end
    endtask

    task automatic test_madd();
`ifndef MDU_MADD_EN
        int seen;
`endif
        bus.wr_hi = 1; bus.wdata = 32'd0;
        tick();
        bus.wr_hi = 0; bus.wr_lo = 1; bus.wdata = 32'hFFFF_FFFF;
        tick();
        bus.wr_lo = 0;
        exp_hi = 32'd0;
        exp_lo = 32'hFFFF_FFFF;
`ifdef MDU_MADD_EN
        run_op(3'd5, 32'd1, 32'd1, "maddu_carry", 1);
        checks++;
        if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL maddu_const: hi=%h lo=%h want 00000001 00000000", bus.hi, bus.lo);
        end
        for (int i = 0; i < 4; i++)
            run_op(3'($urandom_range(4, 5)), $urandom, $urandom, "madd_rand", 1);
`else
        bus.start = 1; bus.op = 3'd5; bus.a = 32'd1; bus.b = 32'd1;
        tick();
        bus.start = 0;
        seen = 0;
        for (int i = 0; i < 36; i++) begin
            if (bus.busy || bus.done) seen++;
            tick();
        end
        checks++;
        if (seen !== 0 || bus.hi !== 32'd0 || bus.lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL maddu_disabled: active=%0d hi=%h lo=%h want 0 00000000 ffffffff", seen, bus.hi, bus.lo);
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++)
            run_op(3'($urandom_range(0, 3)), $urandom, 32'($urandom_range(0, 1000)), "b2b", i == 4);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_cancel_mthi();
        test_step4();
        test_madd();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
